vdp_run_sequencer: RTL and testbench
====================================

Name: vdp_run_sequencer

Overview:
Top-level run scheduler for the Van der Pol integrator. It loads initial conditions, issues N single-step requests to the per-step datapath controller and waits for each step to complete. After every D-th completed step it captures the datapath x/y state into a valid/ready sample stream. A stalled step controller is flagged by a watchdog. The block sits between the host/config logic and the step controller plus datapath.

Parameters:
DATA_W, 16, width of x/y state words (fixed-point, passed through unmodified)
CNT_W, 16, width of the step count and sample index
DECIM_W, 8, width of the decimation factor
TIMEOUT, 16, max cycles in WAIT without step_done before error (must be >=6)

Ports:
clk  in  1  system clock, all logic on rising edge
reset_n  in  1  synchronous reset, active-low
run  in  1  level; rising or held high in IDLE starts a run
abort  in  1  pulse/level; cancels the run from any state
cfg_num_steps  in  CNT_W  number of Euler steps; latched at start
cfg_decim  in  DECIM_W  emit one sample every cfg_decim steps; 0 treated as 1; latched at start
load_init  out  1  one-cycle pulse: datapath loads x0/y0
step_start  out  1  one-cycle pulse to the step controller
step_done  in  1  step-complete pulse from the step controller
dp_x  in  DATA_W  current datapath x
dp_y  in  DATA_W  current datapath y
smp_valid  out  1  sample available
smp_ready  in  1  consumer accepts sample
smp_x  out  DATA_W  captured x
smp_y  out  DATA_W  captured y
smp_idx  out  CNT_W  step number of the sample (1-based)
busy  out  1  high in every state except IDLE, DONE, ERR
finished  out  1  high in DONE
err  out  1  high in ERR (watchdog expiry)

Behaviour:
- Reset (reset_n=0 at clk edge): state=IDLE; all outputs 0; counters 0. Reset mid-run drops any pending sample; no further step_start is issued.
- States: IDLE, INIT, ISSUE, WAIT, EMIT, DONE, ERR.
- IDLE: if run=1 and abort=0, latch cfg_num_steps into n_lat and max(cfg_decim,1) into d_lat; clear step_cnt and dec_cnt; go to INIT.
- INIT: load_init=1 for this cycle only. Next state is DONE if n_lat==0, else ISSUE.
- ISSUE: step_start=1 for this cycle only. Next state is WAIT; clear wd_cnt.
- WAIT: step_done is honoured only in this state (ignored elsewhere).
  - On step_done: step_cnt+=1; dec_cnt+=1.
  - If dec_cnt+1==d_lat: dec_cnt<=0; capture dp_x/dp_y into smp_x/smp_y and step_cnt+1 into smp_idx in the same cycle; go to EMIT.
  - Otherwise go to DONE if step_cnt+1==n_lat, else ISSUE.
  - Without step_done: wd_cnt+=1; when wd_cnt reaches TIMEOUT-1, go to ERR.
- EMIT: smp_valid=1. smp_x/smp_y/smp_idx stay stable until the handshake. On smp_valid&&smp_ready, go to DONE if step_cnt==n_lat, else ISSUE. Backpressure may hold EMIT indefinitely; no new step is issued meanwhile.
- The final step always emits when n_lat is a multiple of d_lat. Remainder steps produce no sample.
- DONE: finished=1. Stays while run=1; returns to IDLE when run=0.
- ERR: err=1. Stays until run=0 or abort=1, then returns to IDLE.
- abort=1 in any non-IDLE state: next state is IDLE and smp_valid drops. A sample presented in the abort cycle counts as not transferred. abort has priority over step_done and over the handshake.
- Simultaneous run and abort in IDLE: remain in IDLE.
- Throughput: step period is 2 + step-controller latency cycles. Step-controller latency is 5 (start sample to done).
- Counters are unsigned and do not wrap, because n_lat bounds step_cnt. step_cnt==2^CNT_W-1 is a legal maximum.

Decomposition:
- Shared package vdp_pkg: state encodings, default DATA_W/CNT_W/DECIM_W, and the TIMEOUT constant. The step controller and this sequencer both import it.
- One sub-module, vdp_step_watchdog: counter with clear, enable and an expiry output, parameterised by TIMEOUT.

Test Plan:
- num_steps=4, decim=1, ready=1, step controller model with 5-cycle done -> exactly 4 step_start pulses, samples idx 1,2,3,4 carrying the model's x/y; finished=1; one load_init.
- num_steps=10, decim=3, ready=1 -> samples idx 3,6,9 only; 10 step_start pulses; DONE reached after step 10 with no sample for step 10.
- num_steps=0 -> load_init once, no step_start, finished=1 two cycles after run.
- num_steps=2, decim=0, smp_ready low for 20 cycles -> smp_valid held with stable idx=1 data; second step_start issued only after the accepting cycle.
- step model never returns done, TIMEOUT=16 -> err=1 exactly 16 cycles after step_start; run=0 returns to IDLE.
- abort asserted in WAIT, then in EMIT with pending sample; reset_n=0 mid-run -> IDLE next cycle, smp_valid=0, no further step_start; new run restarts at idx 1.

Source files
------------

// File: rtl/vdp_pkg.sv
// Shared constants for the Van der Pol integrator: default widths, watchdog
// limit and the run-sequencer state encodings.
package vdp_pkg;

    localparam int DATA_W_DEF  = 16;
    localparam int CNT_W_DEF   = 16;
    localparam int DECIM_W_DEF = 8;
    localparam int TIMEOUT_DEF = 16;
    localparam int STEP_LAT    = 5;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_INIT  = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_EMIT  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;
    localparam logic [2:0] S_ERR   = 3'd6;

endpackage

// File: rtl/vdp_step_watchdog.sv
// Cycle counter guarding the wait for step_done; expired fires on the cycle
// whose increment takes the count to TIMEOUT-1.
module vdp_step_watchdog
    import vdp_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int WD_W = $clog2(TIMEOUT);

    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;

    always_comb begin
        wd_cnt_d = wd_cnt_q;
        if (clr) begin
            wd_cnt_d = '0;
        end else if (en) begin
            wd_cnt_d = wd_cnt_q + WD_W'(1);
        end
    end

    assign expired = en && !clr && (wd_cnt_q == WD_W'(TIMEOUT - 2));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wd_cnt_q <= '0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
        end
    end

endmodule

// File: rtl/vdp_run_sequencer.sv
// Run scheduler: loads initial conditions, issues single steps, decimates the
// datapath state into a valid/ready sample stream and flags a stalled step.
module vdp_run_sequencer
    import vdp_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int DECIM_W = DECIM_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               run,
    input  logic               abort,
    input  logic [CNT_W-1:0]   cfg_num_steps,
    input  logic [DECIM_W-1:0] cfg_decim,
    output logic               load_init,
    output logic               step_start,
    input  logic               step_done,
    input  logic [DATA_W-1:0]  dp_x,
    input  logic [DATA_W-1:0]  dp_y,
    output logic               smp_valid,
    input  logic               smp_ready,
    output logic [DATA_W-1:0]  smp_x,
    output logic [DATA_W-1:0]  smp_y,
    output logic [CNT_W-1:0]   smp_idx,
    output logic               busy,
    output logic               finished,
    output logic               err
);

    logic [2:0]         state_q, state_d;
    logic [CNT_W-1:0]   n_lat_q, n_lat_d;
    logic [CNT_W-1:0]   step_cnt_q, step_cnt_d;
    logic [CNT_W-1:0]   smp_idx_q, smp_idx_d;
    logic [DECIM_W-1:0] d_lat_q, d_lat_d;
    logic [DECIM_W-1:0] dec_cnt_q, dec_cnt_d;
    logic [DATA_W-1:0]  smp_x_q, smp_x_d;
    logic [DATA_W-1:0]  smp_y_q, smp_y_d;

    logic [CNT_W-1:0]   step_inc;
    logic [DECIM_W-1:0] dec_inc;
    logic               wd_clr, wd_en, wd_expired;

    assign step_inc = step_cnt_q + CNT_W'(1);
    assign dec_inc  = dec_cnt_q + DECIM_W'(1);
    assign wd_clr   = (state_q == S_ISSUE);
    assign wd_en    = (state_q == S_WAIT) && !step_done && !abort;

    vdp_step_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (wd_clr),
        .en      (wd_en),
        .expired (wd_expired)
    );

    always_comb begin
        state_d    = state_q;
        n_lat_d    = n_lat_q;
        d_lat_d    = d_lat_q;
        step_cnt_d = step_cnt_q;
        dec_cnt_d  = dec_cnt_q;
        smp_idx_d  = smp_idx_q;
        smp_x_d    = smp_x_q;
        smp_y_d    = smp_y_q;
        case (state_q)
            S_IDLE: begin
                if (run && !abort) begin
                    n_lat_d    = cfg_num_steps;
                    d_lat_d    = (cfg_decim == '0) ? DECIM_W'(1) : cfg_decim;
                    step_cnt_d = '0;
                    dec_cnt_d  = '0;
                    state_d    = S_INIT;
                end
            end
            S_INIT:  state_d = (n_lat_q == '0) ? S_DONE : S_ISSUE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (step_done) begin
                    step_cnt_d = step_inc;
                    if (dec_inc == d_lat_q) begin
                        dec_cnt_d = '0;
                        smp_idx_d = step_inc;
                        smp_x_d   = dp_x;
                        smp_y_d   = dp_y;
                        state_d   = S_EMIT;
                    end else begin
                        dec_cnt_d = dec_inc;
                        state_d   = (step_inc == n_lat_q) ? S_DONE : S_ISSUE;
                    end
                end else if (wd_expired) begin
                    state_d = S_ERR;
                end
            end
            S_EMIT: begin
                if (smp_ready) begin
                    state_d = (step_cnt_q == n_lat_q) ? S_DONE : S_ISSUE;
                end
            end
            S_DONE:  if (!run) state_d = S_IDLE;
            S_ERR:   if (!run) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // abort outranks step_done and the sample handshake
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            n_lat_q    <= '0;
            d_lat_q    <= '0;
            step_cnt_q <= '0;
            dec_cnt_q  <= '0;
            smp_idx_q  <= '0;
            smp_x_q    <= '0;
            smp_y_q    <= '0;
        end else begin
            state_q    <= state_d;
            n_lat_q    <= n_lat_d;
            d_lat_q    <= d_lat_d;
            step_cnt_q <= step_cnt_d;
            dec_cnt_q  <= dec_cnt_d;
            smp_idx_q  <= smp_idx_d;
            smp_x_q    <= smp_x_d;
            smp_y_q    <= smp_y_d;
        end
    end

    assign load_init  = (state_q == S_INIT);
    assign step_start = (state_q == S_ISSUE);
    assign smp_valid  = (state_q == S_EMIT);
    assign smp_x      = smp_x_q;
    assign smp_y      = smp_y_q;
    assign smp_idx    = smp_idx_q;
    assign finished   = (state_q == S_DONE);
    assign err        = (state_q == S_ERR);
    assign busy       = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERR);

endmodule

// File: tb/tb_vdp_run_sequencer.sv
// Bench for vdp_run_sequencer: step-controller/datapath model plus a sample
// monitor, with per-scenario tasks checked against an expected sample list.
module tb_vdp_run_sequencer;

    localparam int DATA_W  = 16;
    localparam int CNT_W   = 16;
    localparam int DECIM_W = 8;
    localparam int TIMEOUT = 16;
    localparam int LAT     = 5;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic               run = 1'b0;
    logic               abort = 1'b0;
    logic [CNT_W-1:0]   cfg_num_steps = '0;
    logic [DECIM_W-1:0] cfg_decim = '0;
    logic               load_init, step_start;
    logic               step_done = 1'b0;
    logic [DATA_W-1:0]  dp_x = '0;
    logic [DATA_W-1:0]  dp_y = '0;
    logic               smp_valid;
    logic               smp_ready = 1'b1;
    logic [DATA_W-1:0]  smp_x, smp_y;
    logic [CNT_W-1:0]   smp_idx;
    logic               busy, finished, err;

    int tests_run = 0;
    int tests_failed = 0;

    vdp_run_sequencer #(
        .DATA_W(DATA_W), .CNT_W(CNT_W), .DECIM_W(DECIM_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset_n(reset_n), .run(run), .abort(abort),
        .cfg_num_steps(cfg_num_steps), .cfg_decim(cfg_decim),
        .load_init(load_init), .step_start(step_start), .step_done(step_done),
        .dp_x(dp_x), .dp_y(dp_y), .smp_valid(smp_valid), .smp_ready(smp_ready),
        .smp_x(smp_x), .smp_y(smp_y), .smp_idx(smp_idx),
        .busy(busy), .finished(finished), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // datapath state after step k is a fixed function of k and the run seed
    logic [15:0] seed_x = 16'h1234;
    logic [15:0] seed_y = 16'h8765;
    function automatic logic [15:0] fx(input int kk);
        return 16'(kk * 32'h1357) ^ seed_x;
    endfunction
    function automatic logic [15:0] fy(input int kk);
        return 16'(kk * 32'h0f0f) + seed_y;
    endfunction

    // step controller model (done LAT cycles after step_start) and monitor
    bit hang = 1'b0;
    int cd = 0, k = 0, n_start = 0, n_load = 0, last_start_cyc = 0;
    logic [47:0] got[$];
    always @(negedge clk) begin
        if (!reset_n) begin
            cd        <= 0;
            step_done <= 1'b0;
        end else begin
            if (load_init) begin
                k      <= 0;
                n_load <= n_load + 1;
            end
            if (cd == 1 && !hang) begin
                step_done <= 1'b1;
                dp_x      <= fx(k + 1);
                dp_y      <= fy(k + 1);
                k         <= k + 1;
            end else begin
                step_done <= 1'b0;
            end
            if (step_start) begin
                cd             <= LAT;
                n_start        <= n_start + 1;
                last_start_cyc <= cyc;
            end else if (cd > 0) begin
                cd <= cd - 1;
            end
            if (smp_valid && smp_ready && !abort) got.push_back({smp_idx, smp_x, smp_y});
        end
    end

    logic [47:0] exp_q[$];
    task automatic build_exp(input int n, input int d);
        int dn;
        dn = (d == 0) ? 1 : d;
        exp_q.delete();
        for (int i = 1; i <= n; i++)
            if (i % dn == 0) exp_q.push_back({16'(i), fx(i), fy(i)});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_run(input int n, input int d, input bit rnd, output bit to);
        cfg_num_steps = 16'(n);
        cfg_decim     = 8'(d);
        run = 1'b1;
        to  = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            tick();
            if (finished) begin
                to = 1'b0;
                break;
            end
            if (rnd) smp_ready = 1'($urandom_range(0, 1));
        end
        run = 1'b0;
        smp_ready = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) tick();
        tests_run++;
        if ({busy, finished, err, smp_valid, load_init, step_start} !== 6'b0) begin
            tests_failed++;
            $display("FAIL reset_flags: got %b expected 000000",
                     {busy, finished, err, smp_valid, load_init, step_start});
        end
        tests_run++;
        if ({smp_idx, smp_x, smp_y} !== 48'h0) begin
            tests_failed++;
            $display("FAIL reset_sample: got %h expected 0", {smp_idx, smp_x, smp_y});
        end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_run(input int n, input int d, input bit rnd);
        int bs, bl, bg, ng;
        bit to;
        bs = n_start; bl = n_load; bg = got.size();
        seed_x = 16'($urandom);
        seed_y = 16'($urandom);
        do_run(n, d, rnd, to);
        build_exp(n, d);
        ng = got.size() - bg;
        tests_run++;
        if (to) begin
            tests_failed++;
            $display("FAIL run_finish n=%0d d=%0d: finished never seen", n, d);
        end
        tests_run++;
        if (ng != exp_q.size()) begin
            tests_failed++;
            $display("FAIL run_nsamples n=%0d d=%0d: got %0d expected %0d", n, d, ng, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < ng; i++) begin
            tests_run++;
            if (got[bg+i] !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL run_sample%0d n=%0d d=%0d: got %h expected %h", i, n, d, got[bg+i], exp_q[i]);
            end
        end
        tests_run++;
        if (n_start - bs != n) begin
            tests_failed++;
            $display("FAIL run_steps n=%0d d=%0d: got %0d expected %0d", n, d, n_start - bs, n);
        end
        tests_run++;
        if (n_load - bl != 1) begin
            tests_failed++;
            $display("FAIL run_loads n=%0d: got %0d expected 1", n, n_load - bl);
        end
        tests_run++;
        if ({busy, finished} !== 2'b00) begin
            tests_failed++;
            $display("FAIL run_idle_after n=%0d: got %b expected 00", n, {busy, finished});
        end
    endtask

    task automatic test_zero_steps();
        int bs, bl;
        bs = n_start; bl = n_load;
        cfg_num_steps = '0;
        cfg_decim = 8'd1;
        run = 1'b1;
        tick();
        tests_run++;
        if ({load_init, finished} !== 2'b10) begin
            tests_failed++;
            $display("FAIL zero_cycle1: got %b expected 10", {load_init, finished});
        end
        tick();
        tests_run++;
        if ({load_init, finished} !== 2'b01) begin
            tests_failed++;
            $display("FAIL zero_cycle2: got %b expected 01", {load_init, finished});
        end
        repeat (8) tick();
        tests_run++;
        if (n_start != bs || n_load - bl != 1 || finished !== 1'b1) begin
            tests_failed++;
            $display("FAIL zero_counts: got starts %0d loads %0d fin %b expected 0 1 1",
                     n_start - bs, n_load - bl, finished);
        end
        run = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_backpressure();
        int bs, bg;
        bit bad, to;
        logic [47:0] held;
        bs = n_start; bg = got.size();
        cfg_num_steps = 16'd2;
        cfg_decim = 8'd0;
        smp_ready = 1'b0;
        run = 1'b1;
        for (int i = 0; i < 100 && !smp_valid; i++) tick();
        held = {smp_idx, smp_x, smp_y};
        tests_run++;
        if (smp_valid !== 1'b1 || held !== {16'd1, fx(1), fy(1)}) begin
            tests_failed++;
            $display("FAIL bp_first: got v=%b %h expected v=1 %h", smp_valid, held, {16'd1, fx(1), fy(1)});
        end
        bad = 1'b0;
        repeat (20) begin
            tick();
            if (smp_valid !== 1'b1 || step_start !== 1'b0 || {smp_idx, smp_x, smp_y} !== held) bad = 1'b1;
        end
        tests_run++;
        if (bad || n_start - bs != 1) begin
            tests_failed++;
            $display("FAIL bp_hold: got unstable=%b starts=%0d expected 0 1", bad, n_start - bs);
        end
        smp_ready = 1'b1;
        tick();
        tests_run++;
        if ({step_start, smp_valid} !== 2'b10) begin
            tests_failed++;
            $display("FAIL bp_release: got %b expected 10", {step_start, smp_valid});
        end
        to = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (finished) begin
                to = 1'b0;
                break;
            end
            tick();
        end
        tests_run++;
        if (to || got.size() - bg != 2 || got[bg+1] !== {16'd2, fx(2), fy(2)}) begin
            tests_failed++;
            $display("FAIL bp_second: got to=%b n=%0d expected 0 2", to, got.size() - bg);
        end
        run = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_timeout();
        int bs, dt;
        bit seen;
        bs = n_start;
        hang = 1'b1;
        cfg_num_steps = 16'd3;
        cfg_decim = 8'd1;
        run = 1'b1;
        seen = 1'b0;
        dt = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (err) begin
                seen = 1'b1;
                dt = cyc - last_start_cyc;
                break;
            end
        end
        tests_run++;
        if (!seen || dt != TIMEOUT) begin
            tests_failed++;
            $display("FAIL timeout_delay: got seen=%b dt=%0d expected 1 %0d", seen, dt, TIMEOUT);
        end
        tests_run++;
        if (busy !== 1'b0 || n_start - bs != 1) begin
            tests_failed++;
            $display("FAIL timeout_state: got busy=%b starts=%0d expected 0 1", busy, n_start - bs);
        end
        run = 1'b0;
        tick();
        tests_run++;
        if ({err, busy} !== 2'b00) begin
            tests_failed++;
            $display("FAIL timeout_exit: got %b expected 00", {err, busy});
        end
        hang = 1'b0;
        repeat (8) tick();
    endtask

    task automatic test_abort_reset();
        int bs, bg;
        bit bad;
        // abort while waiting for a step
        cfg_num_steps = 16'd5;
        cfg_decim = 8'd1;
        run = 1'b1;
        for (int i = 0; i < 50 && !step_start; i++) tick();
        tick();
        tick();
        abort = 1'b1;
        run = 1'b0;
        tick();
        abort = 1'b0;
        tests_run++;
        if ({busy, smp_valid} !== 2'b00) begin
            tests_failed++;
            $display("FAIL abort_wait: got %b expected 00", {busy, smp_valid});
        end
        bad = 1'b0;
        repeat (15) begin
            tick();
            if (step_start !== 1'b0) bad = 1'b1;
        end
        tests_run++;
        if (bad) begin
            tests_failed++;
            $display("FAIL abort_wait_quiet: got step_start after abort, expected none");
        end
        // abort with a sample pending and the consumer ready in the same cycle
        bg = got.size();
        smp_ready = 1'b0;
        run = 1'b1;
        for (int i = 0; i < 50 && !smp_valid; i++) tick();
        abort = 1'b1;
        smp_ready = 1'b1;
        run = 1'b0;
        tick();
        abort = 1'b0;
        tests_run++;
        if ({busy, smp_valid} !== 2'b00 || got.size() != bg) begin
            tests_failed++;
            $display("FAIL abort_emit: got flags %b xfers %0d expected 00 0", {busy, smp_valid}, got.size() - bg);
        end
        repeat (8) tick();
        // synchronous reset mid-run
        bs = n_start;
        cfg_num_steps = 16'd6;
        run = 1'b1;
        for (int i = 0; i < 100 && (n_start - bs) < 2; i++) tick();
        reset_n = 1'b0;
        run = 1'b0;
        tick();
        tests_run++;
        if ({busy, smp_valid, step_start, finished} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_midrun: got %b expected 0000", {busy, smp_valid, step_start, finished});
        end
        reset_n = 1'b1;
        bs = n_start;
        repeat (20) tick();
        tests_run++;
        if (n_start != bs) begin
            tests_failed++;
            $display("FAIL reset_quiet: got %0d step_start after reset expected 0", n_start - bs);
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 5; r++)
            test_run($urandom_range(1, 12), $urandom_range(0, 5), 1'b1);
    endtask

    initial begin
        test_reset();
        test_run(4, 1, 1'b0);
        test_run(10, 3, 1'b0);
        test_zero_steps();
        test_backpressure();
        test_timeout();
        test_abort_reset();
        test_run(3, 1, 1'b0);
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not reach the end, expected completion");
        $fatal(1, "global timeout");
    end

endmodule
